store_fwd_buffer: RTL and testbench
===================================

# store_fwd_buffer

Parametrised store-data forwarding unit for the MEM stage of the 5-stage pipeline. It resolves load-store and delayed-store hazards on the store data operand. It compares the MEM-stage store's rt against the live WB write and against a DEPTH-entry history of recently retired register writes, then delivers the correct store data. The history covers stores that sat stalled in EX/MEM while producers retired and their register-file read went stale. It generalises the single-level WB→MEM store forward with configurable data width, address width and history depth.

## Interface
- DW, 32, data width of register values
- AW, 5, register address width
- DEPTH, 3, history entries, legal 1..8
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wb_reg_wr  in  1  WB stage writes register file this cycle
- wb_reg_addr  in  AW  WB destination register
- wb_reg_data  in  DW  WB write data
- mem_mem_wr  in  1  MEM stage instruction is a store
- mem_rt  in  AW  store data source register
- mem_rt_data  in  DW  rt value carried down the pipeline from ID
- flush  in  1  synchronous clear of history (exception/redirect)
- mem_wr_data  out  DW  store data to data memory
- fwd_hit  out  1  forwarded value selected
- fwd_level  out  4  0 none, 1 live WB, k+2 history entry k
- fwd_cnt  out  32  forward event counter (see Configuration)

## Operation
- Valid WB write: wb_reg_wr=1 and wb_reg_addr≠0.
- History: DEPTH entries {valid, addr, data}, entry 0 newest. Each valid WB write shifts entries up one; entry DEPTH-1 is discarded and entry 0 loads the write. No shift occurs without a valid WB write.
- Lookup (combinational), priority from highest:
  - Live WB: valid WB write with wb_reg_addr==mem_rt.
  - History entries 0..DEPTH-1, lowest index first: valid and addr==mem_rt.
  - Otherwise: mem_rt_data.
- mem_rt==0 never hits. mem_wr_data=0 whenever mem_rt==0, regardless of mem_rt_data.
- fwd_hit and fwd_level are qualified by mem_mem_wr. When mem_mem_wr=0: fwd_hit=0, fwd_level=0, and mem_wr_data still follows the lookup.
- Duplicate addresses may coexist in history. The priority order guarantees the newest value wins.
- flush=1 clears all valid bits at the clock edge. If a valid WB write occurs in the same cycle, it is still captured into entry 0 valid, because the WB instruction is committed. The live WB path is unaffected by flush.

## Timing
- Lookup is zero-latency: outputs are combinational from inputs and history state within the cycle.
- History update and flush take effect at the rising clk edge. A value written in cycle n is forwardable from history in cycles n+1 .. n+DEPTH, counted in valid WB writes, not cycles.
- Reset (async, rst_n=0): all valid bits 0, addr/data 0, fwd_cnt 0.
- Reset outputs, combinational: fwd_hit=0 and fwd_level=0 unless the live WB path hits; mem_wr_data=mem_rt_data.
- Reset asserted mid-stall discards history immediately. After release, only the live WB path can forward until new writes retire.

## Configuration
- STORE_FWD_PERF_CNT_EN defined:
  - fwd_cnt increments by 1 at each rising edge where mem_mem_wr=1 and fwd_hit=1.
  - It saturates at 32'hFFFFFFFF and clears on reset only; flush does not clear it.
- Undefined: counter logic is removed and fwd_cnt is tied to 0.

## Test plan
- Live WB forward: WB writes r8=32'h1234_5678; MEM store with rt=8, mem_rt_data=32'hDEAD -> mem_wr_data=32'h1234_5678, fwd_hit=1, fwd_level=1.
- Stalled store, history hit (DEPTH=3):
  - Setup: WB writes r9=32'hA1 in cycle 0, then r10=32'hB2 and r11=32'hC3 in cycles 1–2.
  - Cycle 3: store rt=9 -> mem_wr_data=32'hA1, fwd_level=4.
  - One more write r12=32'h44 -> r9 evicted; store rt=9 -> mem_wr_data=mem_rt_data, fwd_hit=0.
- Priority: history holds r5=32'h11, then r5=32'h22; live WB writes r5=32'h33 -> mem_wr_data=32'h33, fwd_level=1. Next cycle with no WB write -> mem_wr_data=32'h33, fwd_level=2.
- r0 rule: WB writes r0=32'hFFFF and store rt=0 -> fwd_hit=0, mem_wr_data=0, and no history shift occurs.
- Flush with simultaneous write:
  - Setup: history holds r3, r4; flush=1 while WB writes r6=32'h77.
  - Next cycle: store rt=3 -> no hit; store rt=6 -> mem_wr_data=32'h77, fwd_level=2.
- Reset and counter (macro defined):
  - 5 forwarded stores -> fwd_cnt=5.
  - Assert rst_n=0 mid-cycle -> fwd_cnt=0 and history empty immediately.
  - Macro undefined -> fwd_cnt stays 0 throughout.

Source files
------------

// File: rtl/store_fwd_buffer.sv
// store_fwd_buffer
// Store-data forwarding for the MEM stage. The MEM store's rt operand is
// compared against the live WB write and against a DEPTH-entry history of
// recently retired register writes, and the newest matching value is driven
// as store data.
//
// Optional feature macro: STORE_FWD_PERF_CNT_EN
//   defined   -> fwd_cnt counts forwarded stores (saturating, cleared by reset only)
//   undefined -> fwd_cnt is tied to zero
//
// DEPTH must lie in 1..8 so that fwd_level (k+2) fits in four bits.

module store_fwd_buffer #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wb_reg_wr,
    input  logic [AW-1:0] wb_reg_addr,
    input  logic [DW-1:0] wb_reg_data,
    input  logic          mem_mem_wr,
    input  logic [AW-1:0] mem_rt,
    input  logic [DW-1:0] mem_rt_data,
    input  logic          flush,
    output logic [DW-1:0] mem_wr_data,
    output logic          fwd_hit,
    output logic [3:0]    fwd_level,
    output logic [31:0]   fwd_cnt
);

    // A write to r0 is architecturally discarded, so it neither forwards nor enters history
    logic          wb_valid_s;
    logic          hit_s;
    logic [3:0]    level_s;
    logic [DW-1:0] data_s;
    logic          found_s;

    logic [DEPTH-1:0] hist_valid_r;
    logic [AW-1:0]    hist_addr_r [DEPTH];
    logic [DW-1:0]    hist_data_r [DEPTH];

    assign wb_valid_s = wb_reg_wr && (wb_reg_addr != {AW{1'b0}});

    // History shift register: entry 0 takes each valid WB write; flush drops older entries' valid bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist_valid_r[i] <= 1'b0;
                hist_addr_r[i]  <= {AW{1'b0}};
                hist_data_r[i]  <= {DW{1'b0}};
            end
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                if (wb_valid_s) begin
                    hist_valid_r[i] <= hist_valid_r[i-1] & ~flush;
                    hist_addr_r[i]  <= hist_addr_r[i-1];
                    hist_data_r[i]  <= hist_data_r[i-1];
                end else if (flush) begin
                    hist_valid_r[i] <= 1'b0;
                end
            end
            // The committed WB write survives a simultaneous flush
            if (wb_valid_s) begin
                hist_valid_r[0] <= 1'b1;
                hist_addr_r[0]  <= wb_reg_addr;
                hist_data_r[0]  <= wb_reg_data;
            end else if (flush) begin
                hist_valid_r[0] <= 1'b0;
            end
        end
    end

    // Priority lookup: live WB first, then history from newest to oldest, else the pipeline value
    always_comb begin
        hit_s   = 1'b0;
        level_s = 4'd0;
        data_s  = mem_rt_data;
        found_s = 1'b0;
        if (mem_rt != {AW{1'b0}}) begin
            if (wb_valid_s && (wb_reg_addr == mem_rt)) begin
                hit_s   = 1'b1;
                level_s = 4'd1;
                data_s  = wb_reg_data;
                found_s = 1'b1;
            end else begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (!found_s && hist_valid_r[k] && (hist_addr_r[k] == mem_rt)) begin
                        hit_s   = 1'b1;
                        level_s = 4'(k + 2);
                        data_s  = hist_data_r[k];
                        found_s = 1'b1;
                    end else begin
                        found_s = found_s;
                    end
                end
            end
        end else begin
            data_s = {DW{1'b0}};
        end
    end

    // Hit indication only means something for an actual store; data always follows the lookup
    always_comb begin
        mem_wr_data = data_s;
        if (mem_mem_wr) begin
            fwd_hit   = hit_s;
            fwd_level = level_s;
        end else begin
            fwd_hit   = 1'b0;
            fwd_level = 4'd0;
        end
    end

`ifdef STORE_FWD_PERF_CNT_EN
    logic [31:0] cnt_r;

    // Saturating count of forwarded stores; flush leaves it untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 32'd0;
        end else if (mem_mem_wr && hit_s && (cnt_r != 32'hFFFF_FFFF)) begin
            cnt_r <= cnt_r + 32'd1;
        end
    end

    assign fwd_cnt = cnt_r;
`else
    assign fwd_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_store_fwd_buffer.sv
// Scoreboard bench for store_fwd_buffer. A queue-based reference history
// (newest at the front) predicts each cycle's outputs; a monitor on the
// falling edge pops predictions and compares them with the DUT.

module tb_store_fwd_buffer;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 3;

    logic          clk;
    logic          rst_n;
    logic          wb_reg_wr;
    logic [AW-1:0] wb_reg_addr;
    logic [DW-1:0] wb_reg_data;
    logic          mem_mem_wr;
    logic [AW-1:0] mem_rt;
    logic [DW-1:0] mem_rt_data;
    logic          flush;
    logic [DW-1:0] mem_wr_data;
    logic          fwd_hit;
    logic [3:0]    fwd_level;
    logic [31:0]   fwd_cnt;

    store_fwd_buffer #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_reg_wr   (wb_reg_wr),
        .wb_reg_addr (wb_reg_addr),
        .wb_reg_data (wb_reg_data),
        .mem_mem_wr  (mem_mem_wr),
        .mem_rt      (mem_rt),
        .mem_rt_data (mem_rt_data),
        .flush       (flush),
        .mem_wr_data (mem_wr_data),
        .fwd_hit     (fwd_hit),
        .fwd_level   (fwd_level),
        .fwd_cnt     (fwd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          hit;
        logic [3:0]    level;
        logic [31:0]   cnt;
    } exp_t;

    ent_t        hist[$];
    exp_t        exp_q[$];
    logic [31:0] m_cnt;
    logic        m_hit;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        hist = {};
        for (int i = 0; i < DEPTH; i++) hist.push_back('{1'b0, '0, '0});
        m_cnt = 32'd0;
    endtask

    // Effect of one rising edge with the inputs currently applied
    task automatic model_edge();
        ent_t e;
        if (!rst_n) begin
            model_clear();
        end else begin
            if (mem_mem_wr && m_hit && m_cnt != 32'hFFFF_FFFF) begin
`ifdef STORE_FWD_PERF_CNT_EN
                m_cnt = m_cnt + 32'd1;
`endif
            end
            if (flush) for (int i = 0; i < DEPTH; i++) hist[i].v = 1'b0;
            if (wb_reg_wr && wb_reg_addr != 0) begin
                e.v = 1'b1; e.a = wb_reg_addr; e.d = wb_reg_data;
                hist.push_front(e);
                void'(hist.pop_back());
            end
        end
    endtask

    // Expected outputs for the inputs currently applied
    task automatic model_predict();
        exp_t x;
        logic          h;
        int            lvl;
        logic [DW-1:0] d;
        if (!rst_n) model_clear();
        h = 1'b0; lvl = 0; d = mem_rt_data;
        if (mem_rt == 0) begin
            d = '0;
        end else if (wb_reg_wr && wb_reg_addr != 0 && wb_reg_addr == mem_rt) begin
            h = 1'b1; lvl = 1; d = wb_reg_data;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!h && hist[i].v && hist[i].a == mem_rt) begin
                    h = 1'b1; lvl = i + 2; d = hist[i].d;
                end
            end
        end
        m_hit   = h;
        x.data  = d;
        x.hit   = mem_mem_wr && h;
        x.level = mem_mem_wr ? 4'(lvl) : 4'd0;
        x.cnt   = m_cnt;
        exp_q.push_back(x);
    endtask

    task automatic cyc(input logic rst, input logic wr, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic mw, input logic [AW-1:0] rt,
                       input logic [DW-1:0] rtd, input logic fl);
        @(posedge clk);
        model_edge();
        #1;
        rst_n = rst; wb_reg_wr = wr; wb_reg_addr = wa; wb_reg_data = wd;
        mem_mem_wr = mw; mem_rt = rt; mem_rt_data = rtd; flush = fl;
        model_predict();
    endtask

    // Monitor: every falling edge with a pending prediction is compared
    always @(negedge clk) begin
        exp_t x;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("mem_wr_data", mem_wr_data, x.data);
            chk("fwd_hit", {31'd0, fwd_hit}, {31'd0, x.hit});
            chk("fwd_level", {28'd0, fwd_level}, {28'd0, x.level});
            chk("fwd_cnt", fwd_cnt, x.cnt);
        end
    end

    initial begin
        rst_n = 1'b0; wb_reg_wr = 1'b0; wb_reg_addr = '0; wb_reg_data = '0;
        mem_mem_wr = 1'b0; mem_rt = '0; mem_rt_data = '0; flush = 1'b0;
        m_hit = 1'b0;
        model_clear();

        // Reset state, including a live WB hit during reset
        cyc(0, 0, 0, 0, 1, 7, 32'hCAFE_0001, 0);
        cyc(0, 1, 7, 32'h99, 1, 7, 32'hCAFE_0002, 0);
        // Live WB forward
        cyc(1, 1, 8, 32'h1234_5678, 1, 8, 32'hDEAD, 0);
        // Stalled store, history hit then eviction
        cyc(1, 1, 9, 32'hA1, 0, 0, 0, 0);
        cyc(1, 1, 10, 32'hB2, 0, 0, 0, 0);
        cyc(1, 1, 11, 32'hC3, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 9, 32'h5555, 0);
        cyc(1, 1, 12, 32'h44, 0, 9, 32'h6666, 0);
        cyc(1, 0, 0, 0, 1, 9, 32'h7777, 0);
        // Duplicate addresses: newest wins
        cyc(1, 1, 5, 32'h11, 0, 0, 0, 0);
        cyc(1, 1, 5, 32'h22, 0, 0, 0, 0);
        cyc(1, 1, 5, 32'h33, 1, 5, 32'h1, 0);
        cyc(1, 0, 0, 0, 1, 5, 32'h2, 0);
        // r0: never hits, forces zero, no shift
        cyc(1, 1, 0, 32'hFFFF, 1, 0, 32'hABCD, 0);
        cyc(1, 0, 0, 0, 1, 5, 32'h3, 0);
        // Non-store still forwards data but reports no hit
        cyc(1, 0, 0, 0, 0, 5, 32'h4, 0);
        // Flush with simultaneous write
        cyc(1, 1, 3, 32'h3333, 0, 0, 0, 0);
        cyc(1, 1, 4, 32'h4444, 0, 0, 0, 0);
        cyc(1, 1, 6, 32'h77, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1, 3, 32'hBEEF, 0);
        cyc(1, 0, 0, 0, 1, 4, 32'hBEEF, 0);
        cyc(1, 0, 0, 0, 1, 6, 32'hBEEF, 0);
        // Five forwarded stores, then mid-cycle reset and release
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1, 6, 32'h0, 0);
        cyc(1, 0, 0, 0, 1, 6, 32'h0, 0);
        cyc(0, 0, 0, 0, 1, 6, 32'h1, 0);
        cyc(1, 0, 0, 0, 1, 6, 32'h2, 0);

        // Randomised traffic over a small register window to provoke hits
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                AW'($urandom_range(0, 7)),
                DW'($urandom),
                ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                AW'($urandom_range(0, 7)),
                DW'($urandom),
                ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0);
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
